enum_rr_arbiter: RTL and testbench



---
 rtl/enum_rr_arbiter_if.sv | 39 +++
 rtl/enum_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_enum_rr_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/enum_rr_arbiter_if.sv
// ============================================================================
// Module      : enum_rr_arbiter_if
// Description : Request/grant bundle between requesters and enum_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface enum_rr_arbiter_if #(
    parameter int N = 4
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            busy;
    logic            timeout;
    logic [1:0]      state_o;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout,
        input  state_o
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output busy,
        output timeout,
        output state_o
    );
endinterface

`default_nettype wire

// File: rtl/enum_rr_arbiter.sv
// ============================================================================
// Module      : enum_rr_arbiter
// Description : Round-robin arbiter with hold-timeout granting one requester
//               exclusive ownership of a shared resource at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enum_rr_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    enum_rr_arbiter_if.slave   bus
);

    localparam int ID_W  = $clog2(N);
    localparam int SUM_W = ID_W + 1;
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    localparam logic [N-1:0]     c_one   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]  c_last  = ID_W'(N - 1);
    localparam logic [SUM_W-1:0] c_n     = SUM_W'(N);
    localparam logic [CNT_W-1:0] c_hold  = CNT_W'(HOLD_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]    r_grant;
    logic [ID_W-1:0] r_grant_id;
    logic            r_busy;
    logic            r_timeout;

    logic [N-1:0]     w_rot;
    logic [SUM_W-1:0] w_off;
    logic [SUM_W-1:0] w_sum;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_next_ptr;
    logic             w_owner_req;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit
    // of the rotated vector is the round-robin winner's offset from ptr.
    always_comb begin
        w_rot = N'({bus.req, bus.req} >> r_ptr);
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SUM_W'(i);
            end
        end
        w_sum    = {1'b0, r_ptr} + w_off;
        w_winner = ID_W'((w_sum >= c_n) ? (w_sum - c_n) : w_sum);
    end

    assign w_next_ptr  = (r_grant_id == c_last) ? '0 : (r_grant_id + ID_W'(1));
    assign w_owner_req = bus.req[r_grant_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (|bus.req) begin
                        r_grant_id <= w_winner;
                        r_grant    <= c_one << w_winner;
                        r_cnt      <= CNT_W'(1);
                        r_busy     <= 1'b1;
                        r_state    <= ST_GRANT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req || (r_cnt == c_hold)) begin
                        // Owner still requesting here means the hold limit revoked it
                        r_timeout <= w_owner_req;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_ptr     <= w_next_ptr;
                        r_state   <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    r_timeout <= 1'b0;
                    r_state   <= (|bus.req) ? ST_ARB : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = r_busy;
    assign bus.timeout  = r_timeout;
    assign bus.state_o  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_enum_rr_arbiter.sv
// ============================================================================
// Module      : tb_enum_rr_arbiter
// Description : Directed self-checking bench for enum_rr_arbiter (N=4, HOLD_MAX=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enum_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    enum_rr_arbiter_if #(.N(4)) bus ();

    enum_rr_arbiter #(
        .N        (4),
        .HOLD_MAX (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        tick();
        tick();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", bus.grant); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", bus.grant_id); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.timeout); end
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state_o); end
        rst = 1'b0;
        tick();
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL idle_hold_state got %0d exp 0", bus.state_o); end
    endtask

    task automatic test_single();
        bus.req = 4'b0001;
        tick();
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL single_arb_state got %0d exp 1", bus.state_o); end
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_arb_grant got %b exp 0000", bus.grant); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (bus.grant !== 4'b0001 || bus.busy !== 1'b1 || bus.state_o !== 2'd2) begin
                errors++; $display("FAIL single_grant cyc %0d got grant=%b busy=%b state=%0d exp 0001/1/2", c, bus.grant, bus.busy, bus.state_o);
            end
            checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL single_timeout got %b exp 0", bus.timeout); end
        end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.state_o !== 2'd3 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_release got state=%0d grant=%b busy=%b exp 3/0000/0", bus.state_o, bus.grant, bus.busy);
        end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL single_release_timeout got %b exp 0", bus.timeout); end
        tick();
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL single_idle got %0d exp 0", bus.state_o); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL single_last_id got %0d exp 0", bus.grant_id); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL rr_grant %0d got %b exp %b", k, bus.grant, exp_g); end
            checks++; if (bus.grant_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_grant_id %0d got %0d exp %0d", k, bus.grant_id, k % 4); end
            if (k == 4) begin
                bus.req = 4'b0000;
            end else begin
                bus.req = 4'b1111 & ~exp_g;
            end
            tick();
            checks++; if (bus.grant !== 4'b0000 || bus.state_o !== 2'd3) begin
                errors++; $display("FAIL rr_gap1 %0d got grant=%b state=%0d exp 0000/3", k, bus.grant, bus.state_o);
            end
            if (k < 4) begin
                bus.req = 4'b1111;
                tick();
                checks++; if (bus.grant !== 4'b0000 || bus.state_o !== 2'd1) begin
                    errors++; $display("FAIL rr_gap2 %0d got grant=%b state=%0d exp 0000/1", k, bus.grant, bus.state_o);
                end
                tick();
            end
        end
        tick();
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL rr_idle got %0d exp 0", bus.state_o); end
    endtask

    task automatic test_timeout();
        bus.req = 4'b0100;
        tick();
        tick();
        for (int c = 0; c < 8; c++) begin
            checks++; if (bus.grant !== 4'b0100 || bus.timeout !== 1'b0) begin
                errors++; $display("FAIL to_hold cyc %0d got grant=%b timeout=%b exp 0100/0", c, bus.grant, bus.timeout);
            end
            tick();
        end
        checks++; if (bus.timeout !== 1'b1 || bus.state_o !== 2'd3 || bus.grant !== 4'b0000) begin
            errors++; $display("FAIL to_pulse got timeout=%b state=%0d grant=%b exp 1/3/0000", bus.timeout, bus.state_o, bus.grant);
        end
        tick();
        checks++; if (bus.timeout !== 1'b0 || bus.state_o !== 2'd1) begin
            errors++; $display("FAIL to_pulse_end got timeout=%b state=%0d exp 0/1", bus.timeout, bus.state_o);
        end
        tick();
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL to_regrant got %b exp 0100", bus.grant); end
        bus.req = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL to_hold2 cyc %0d got %b exp 0100", c, bus.grant); end
            tick();
        end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL to_pulse2 got %b exp 1", bus.timeout); end
        tick();
        tick();
        checks++; if (bus.grant !== 4'b0001 || bus.grant_id !== 2'd0) begin
            errors++; $display("FAIL to_fair got grant=%b id=%0d exp 0001/0", bus.grant, bus.grant_id);
        end
        bus.req = 4'b0000;
        tick();
        tick();
        checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL to_idle got %0d exp 0", bus.state_o); end
    endtask

    task automatic test_withdraw();
        bus.req = 4'b0010;
        tick();
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL wd_arb got %0d exp 1", bus.state_o); end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.state_o !== 2'd0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL wd_idle got state=%0d grant=%b busy=%b exp 0/0000/0", bus.state_o, bus.grant, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0100;
        tick();
        tick();
        checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL rm_pre got %b exp 0100", bus.grant); end
        bus.req = 4'b0000;
        tick();
        tick();
        bus.req = 4'b1000;
        tick();
        tick();
        for (int c = 0; c < 4; c++) tick();
        checks++; if (bus.grant !== 4'b1000 || bus.grant_id !== 2'd3) begin
            errors++; $display("FAIL rm_owner got grant=%b id=%0d exp 1000/3", bus.grant, bus.grant_id);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.grant !== 4'b0000 || bus.state_o !== 2'd0 || bus.grant_id !== 2'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rm_reset got grant=%b state=%0d id=%0d busy=%b exp 0000/0/0/0", bus.grant, bus.state_o, bus.grant_id, bus.busy);
        end
        bus.req = 4'b1010;
        tick();
        checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL rm_arb got %0d exp 1", bus.state_o); end
        tick();
        checks++; if (bus.grant !== 4'b0010 || bus.grant_id !== 2'd1) begin
            errors++; $display("FAIL rm_first got grant=%b id=%0d exp 0010/1", bus.grant, bus.grant_id);
        end
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_churn();
        bus.req = 4'b0001;
        tick();
        tick();
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL ch_start got %b exp 0001", bus.grant); end
        for (int c = 1; c < 8; c++) begin
            bus.req = (c % 2 == 1) ? 4'b1011 : 4'b0101;
            tick();
            checks++; if (bus.grant !== 4'b0001 || bus.timeout !== 1'b0) begin
                errors++; $display("FAIL ch_hold cyc %0d got grant=%b timeout=%b exp 0001/0", c, bus.grant, bus.timeout);
            end
        end
        tick();
        checks++; if (bus.grant !== 4'b0000 || bus.timeout !== 1'b1) begin
            errors++; $display("FAIL ch_revoke got grant=%b timeout=%b exp 0000/1", bus.grant, bus.timeout);
        end
        bus.req = 4'b0000;
        tick();
        checks++; if (bus.state_o !== 2'd0 || bus.timeout !== 1'b0) begin
            errors++; $display("FAIL ch_idle got state=%0d timeout=%b exp 0/0", bus.state_o, bus.timeout);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.req = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_reset_mid();
        test_churn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
